serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//   Parametrised multi-cycle adder/subtractor for the ALU datapath.
//   - Operands are latched on start and processed CHUNK bits per clock through a chain of full add/sub cells.
//   - The carry/borrow is held in a register between chunks.
//   - Produces the result plus carry/borrow, signed-overflow and zero flags.
//   - Trades latency for area versus a WIDTH-bit ripple chain; sits beside the combinational ALU units.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2)
//   CHUNK  1  bits processed per clock; must divide WIDTH (elaboration error otherwise)
// PORTS
//   clk     in   1      single clock, all state on rising edge
//   rst_n   in   1      synchronous, active-low reset
//   start   in   1      request; sampled only when busy==0
//   mode    in   1      0: a+b, 1: a-b; latched with operands
//   a       in   WIDTH  minuend/augend, latched on accepted start
//   b       in   WIDTH  subtrahend/addend, latched on accepted start
//   busy    out  1      operation in progress
//   done    out  1      one-cycle pulse: result/flags valid
//   result  out  WIDTH  sum/difference (mod 2^WIDTH), held until next accepted start
//   cout    out  1      add: carry out of MSB; sub: borrow out (1 iff a<b unsigned)
//   ovf     out  1      two's-complement overflow of the operation
//   zero    out  1      result == 0
// BEHAVIOUR
//   - Reset (rst_n==0 at an edge): state IDLE; busy=0, done=0, result=0, cout=0, ovf=0, zero=0; internal operand/carry registers cleared.
//   - Reset mid-operation aborts the operation; no done pulse is produced.
//   - FSM states and transitions:
//     - IDLE -> RUN on start at edge E0: latch a, b, mode; clear chunk index.
//     - Carry register init: 0 for add; borrow-in 0 for sub. Subtraction uses full-difference cells, not invert+1.
//     - RUN: edge Ek (k=1..N, N=WIDTH/CHUNK) computes chunk k-1 (LSB first) and writes result bits [(k-1)*CHUNK +: CHUNK].
//     - RUN: the carry/borrow register is updated at each such edge.
//     - RUN -> DONE at edge EN. cout, ovf, zero are registered at EN from final-chunk values.
//     - DONE -> IDLE after one cycle; done=1 only in this DONE cycle.
//   - Latency: done high in the cycle following edge EN, i.e. N cycles after the start edge.
//   - busy=1 in RUN only; busy=0 in IDLE and DONE.
//   - Start handling:
//     - start while busy==1 is ignored (no re-latch).
//     - start during the DONE cycle is accepted (DONE -> RUN) and done still pulses that cycle.
//   - Visibility: result register is observable while in RUN. Its upper bits keep the previous value until written; the result is valid only when done.
//   - Flag definitions:
//     - ovf (add) = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
//     - ovf (sub) = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
//   - Width rules: all arithmetic is mod 2^WIDTH. No sign extension; cout is the only extra bit.
//   - Input sampling: a, b and mode changes after the accepted start have no effect.
// STRUCTURE
//   - Shared include file (alu_defs.vh): mode encodings MODE_ADD=1'b0, MODE_SUB=1'b1; FSM state encodings ST_IDLE, ST_RUN, ST_DONE (2 bits).
//   - Sub-module add_sub_cell (output co, output s, input a, b, ci, sub): one-bit full adder / full difference, gate-level.
//     - In subtract mode it is a borrow cell: borrow = (~a&b) | (~(a^b)&bi).
//     - CHUNK instances are generated in a ripple chain per clock.
//   - Top holds FSM, chunk counter ($clog2(N)+1 bits), operand shift/index logic, carry register and flag registers.
// TESTING
//   - W=8,C=1: sub a=0x05,b=0x03 -> done exactly 8 cycles after start; result=0x02, cout=0, ovf=0, zero=0.
//   - W=8,C=1: sub a=0x03,b=0x05 -> result=0xFE, cout=1 (borrow), ovf=0.
//   - W=8,C=1: sub a=0x80,b=0x01 -> result=0x7F, ovf=1.
//   - W=8,C=1: add a=0xFF,b=0x01 -> result=0x00, cout=1, zero=1, ovf=0.
//   - W=8,C=4: add 0x7F+0x01 -> done 2 cycles after start; result=0x80, ovf=1.
//     Same run: second start asserted while busy (mode/operands changed) is ignored; result unchanged.
//   - W=8,C=1: assert rst_n=0 at cycle 3 of RUN -> next cycle busy=0, done=0, result=0; no done pulse.
//     A new start afterwards completes normally.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared encodings and helpers for the multi-cycle serial adder/subtractor.
package serial_add_sub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow from the operand sign bits and the result sign bit.
    function automatic logic calc_ovf(input logic mode, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
        if (mode == MODE_SUB)
            return (a_msb != b_msb) && (r_msb != a_msb);
        else
            return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_add_sub_cell.sv
// One-bit full adder / full subtractor. When sub=1, co is the borrow out.
module add_sub_cell (
    output logic co,
    output logic s,
    input  logic a,
    input  logic b,
    input  logic ci,
    input  logic sub
);

    logic ax;
    logic axb;

    // ax is a for add and ~a for sub, so one majority form covers carry and borrow.
    assign ax  = a ^ sub;
    assign axb = ax ^ b;
    assign s   = a ^ b ^ ci;
    assign co  = (ax & b) | (ci & axb);

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle add/sub: CHUNK bits per clock, LSB first, carry/borrow held between chunks.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(N) + 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_add_sub: CHUNK must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [CHUNK:0]     chain_c;
    logic [CHUNK-1:0]   chunk_s;
    logic               last_chunk;

    assign chain_c[0] = carry_q;

    // Operands are shifted right each step, so the current chunk always sits at bit 0.
    for (genvar j = 0; j < CHUNK; j++) begin : g_cells
        add_sub_cell u_cell (
            .co  (chain_c[j+1]),
            .s   (chunk_s[j]),
            .a   (a_q[j]),
            .b   (b_q[j]),
            .ci  (chain_c[j]),
            .sub (mode_q)
        );
    end

    assign last_chunk = (idx_q == CNT_W'(N - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == CNT_W'(i))
                        result_d[i*CHUNK +: CHUNK] = chunk_s;
                end
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chain_c[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    state_d = ST_DONE;
                    cout_d  = chain_c[CHUNK];
                    ovf_d   = calc_ovf(mode_q, a_q[CHUNK-1], b_q[CHUNK-1], chunk_s[CHUNK-1]);
                    zero_d  = (result_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: one bit-serial instance and one 4-bit-chunk instance.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start1, mode1;
    logic [7:0] a1, b1;
    logic       busy1, done1, cout1, ovf1, zero1;
    logic [7:0] result1;

    logic       start4, mode4;
    logic [7:0] a4, b4;
    logic       busy4, done4, cout4, ovf4, zero4;
    logic [7:0] result4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    serial_add_sub #(.WIDTH(8), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on the bit-serial instance, then scramble the inputs
    // and count cycles until done (bounded).
    task automatic run_op1(input logic m, input logic [7:0] x, input logic [7:0] y,
                           output int cycles);
        start1 = 1'b1; mode1 = m; a1 = x; b1 = y;
        tick();
        start1 = 1'b0; mode1 = ~m; a1 = ~x; b1 = ~y;
        cycles = 0;
        while (done1 !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_result1(input string name, input int cycles, input logic [7:0] r,
                                 input logic c, input logic o, input logic z);
        tests_run++;
        if (cycles !== 8) begin
            $display("[TB] FAIL %s latency: got %0d cycles, expected 8", name, cycles);
            tests_failed++;
        end
        tests_run++;
        if (result1 !== r) begin
            $display("[TB] FAIL %s result: got %h, expected %h", name, result1, r);
            tests_failed++;
        end
        tests_run++;
        if (cout1 !== c) begin
            $display("[TB] FAIL %s cout: got %b, expected %b", name, cout1, c);
            tests_failed++;
        end
        tests_run++;
        if (ovf1 !== o) begin
            $display("[TB] FAIL %s ovf: got %b, expected %b", name, ovf1, o);
            tests_failed++;
        end
        tests_run++;
        if (zero1 !== z) begin
            $display("[TB] FAIL %s zero: got %b, expected %b", name, zero1, z);
            tests_failed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start1 = 1'b0; mode1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        start4 = 1'b0; mode4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
        tick();
        tick();
        tests_run++;
        if ({busy1, done1, result1, cout1, ovf1, zero1} !== 13'h0) begin
            $display("[TB] FAIL reset_c1: got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b, expected all 0",
                     busy1, done1, result1, cout1, ovf1, zero1);
            tests_failed++;
        end
        tests_run++;
        if ({busy4, done4, result4, cout4, ovf4, zero4} !== 13'h0) begin
            $display("[TB] FAIL reset_c4: got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b, expected all 0",
                     busy4, done4, result4, cout4, ovf4, zero4);
            tests_failed++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sub_basic();
        int cyc;
        run_op1(1'b1, 8'h05, 8'h03, cyc);
        check_result1("sub_05_03", cyc, 8'h02, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_sub_borrow();
        int cyc;
        run_op1(1'b1, 8'h03, 8'h05, cyc);
        check_result1("sub_03_05", cyc, 8'hFE, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_sub_overflow();
        int cyc;
        run_op1(1'b1, 8'h80, 8'h01, cyc);
        check_result1("sub_80_01", cyc, 8'h7F, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_add_wrap();
        int cyc;
        run_op1(1'b0, 8'hFF, 8'h01, cyc);
        check_result1("add_FF_01", cyc, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_chunk4();
        start4 = 1'b1; mode4 = 1'b0; a4 = 8'h7F; b4 = 8'h01;
        tick();
        // A second request while busy, with different mode/operands, must be ignored.
        start4 = 1'b1; mode4 = 1'b1; a4 = 8'h00; b4 = 8'h55;
        tick();
        start4 = 1'b0;
        tests_run++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            $display("[TB] FAIL c4_mid: got busy=%b done=%b, expected busy=1 done=0", busy4, done4);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (done4 !== 1'b1) begin
            $display("[TB] FAIL c4_latency: got done=%b two cycles after start, expected 1", done4);
            tests_failed++;
        end
        tests_run++;
        if (result4 !== 8'h80 || ovf4 !== 1'b1 || cout4 !== 1'b0 || zero4 !== 1'b0) begin
            $display("[TB] FAIL c4_add_7F_01: got result=%h ovf=%b cout=%b zero=%b, expected 80 1 0 0",
                     result4, ovf4, cout4, zero4);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 8'h80) begin
            $display("[TB] FAIL c4_ignored_start: got busy=%b done=%b result=%h, expected 0 0 80",
                     busy4, done4, result4);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit saw_done;
        start1 = 1'b1; mode1 = 1'b0; a1 = 8'h12; b1 = 8'h34;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 8'h00) begin
            $display("[TB] FAIL mid_reset: got busy=%b done=%b result=%h, expected 0 0 00",
                     busy1, done1, result1);
            tests_failed++;
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done1 === 1'b1 || busy1 === 1'b1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            $display("[TB] FAIL mid_reset_abort: got activity after reset, expected none");
            tests_failed++;
        end
        run_op1(1'b0, 8'h12, 8'h34, cyc);
        check_result1("after_reset_add", cyc, 8'h46, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op1(1'b0, 8'h10, 8'h20, cyc);
        check_result1("b2b_first", cyc, 8'h30, 1'b0, 1'b0, 1'b0);
        // Start during the DONE cycle must be accepted.
        run_op1(1'b1, 8'h40, 8'h41, cyc);
        check_result1("b2b_second", cyc, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            $display("[TB] FAIL b2b_idle: got busy=%b done=%b, expected 0 0", busy1, done1);
            tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_sub_basic();
        test_sub_borrow();
        test_sub_overflow();
        test_add_wrap();
        test_chunk4();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
